// File: rtl/apb_regfile_completer.sv
// rtl/apb_regfile_completer.sv - APB register-file completer with wait states and error signalling
//
// Register file of NUM_REGS 32-bit registers behind an APB completer port.
// Register 0 is a read-only identification word; registers 1..NUM_REGS-1 are
// read/write with byte strobes. WAIT_STATES access cycles are inserted with
// pready low before each transfer completes.
//
// Optional build macro: APB_COMPLETER_PROT_EN enables pprot checking against
// the three region bits at the top of paddr.
//
// Ports:
//   pclk     in   clock, rising edge
//   preset   in   asynchronous active-high reset
//   psel     in   completer select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_WIDTH-1:0]
//   pwdata   in   write data [DATA_WIDTH-1:0]
//   pstrb    in   write byte strobes [DATA_WIDTH/8-1:0]
//   pprot    in   protection attributes [2:0]
//   prdata   out  read data (zero unless a clean read is completing/held)
//   pready   out  transfer completion
//   pslverr  out  transfer error, qualified by pready
module apb_regfile_completer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ID_VALUE = 32'hA9B0_0001;

  logic [1:0]            state;
  logic [3:0]            wcnt;
  logic [IDXW-1:0]       idx_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NBYTES-1:0]     strb_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Setup-phase decode of the incoming address.
  logic [IDXW-1:0] idx_in;
  logic            prot_err;
  logic            err_in;
  logic            setup;
  logic            acc_ready;

  assign idx_in = paddr[2+IDXW-1:2];

`ifdef APB_COMPLETER_PROT_EN
  // Each region bit demands the matching pprot attribute.
  assign prot_err = (paddr[ADDR_WIDTH-1] & ~pprot[0])
                  | (paddr[ADDR_WIDTH-2] & ~pprot[1])
                  | (paddr[ADDR_WIDTH-3] & ~pprot[2]);
`else
  logic unused_prot;
  assign unused_prot = ^{pprot, paddr[ADDR_WIDTH-1:ADDR_WIDTH-3]};
  assign prot_err = 1'b0;
`endif

  assign err_in = (|paddr[1:0])
                | (|paddr[ADDR_WIDTH-4:2+IDXW])
                | (pwrite && (idx_in == '0))
                | prot_err;

  // A setup phase (psel high, penable low) is accepted from every state:
  // in IDLE it starts a transfer, in ACCESS it aborts and restarts, and in
  // HOLD it gives back-to-back transfers with no idle cycle.
  assign setup = psel && !penable;

  assign acc_ready = (wcnt == WS);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (setup) begin
      state   <= S_ACCESS;
      wcnt    <= '0;
      idx_q   <= idx_in;
      write_q <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= err_in;
    end else begin
      case (state)
        S_ACCESS: begin
          if (!penable) begin
            state <= S_IDLE;
          end else if (!psel) begin
            // Requester left mid-access: report an error, never write.
            err_q <= 1'b1;
            state <= S_HOLD;
          end else if (acc_ready) begin
            // err_q already covers writes aimed at the read-only register 0.
            if (write_q && !err_q) begin
              for (int b = 0; b < NBYTES; b++) begin
                if (strb_q[b]) begin
                  regs[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
              end
            end
            state <= S_HOLD;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_HOLD: begin
          if (!penable) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registers only change on a write completion, so reading through the
  // captured index also holds prdata steady for the whole HOLD phase.
  logic [DATA_WIDTH-1:0] rsel;
  assign rsel = (idx_q == '0) ? ID_VALUE : regs[idx_q];

  assign pready  = ((state == S_ACCESS) && acc_ready) || (state == S_HOLD);
  assign pslverr = pready && err_q;
  assign prdata  = (pready && !write_q && !err_q) ? rsel : '0;

endmodule
